// File: rtl/calc_pkg.sv
// calc_pkg: opcode constants shared by the RPN calculator, its interface and its bench.
package calc_pkg;
  localparam int OP_W = 3;
  typedef logic [OP_W-1:0] opcode_t;
  localparam opcode_t OP_NOP   = 3'd0;
  localparam opcode_t OP_PUSH  = 3'd1;
  localparam opcode_t OP_POP   = 3'd2;
  localparam opcode_t OP_ADD   = 3'd3;
  localparam opcode_t OP_SUB   = 3'd4;
  localparam opcode_t OP_MUL   = 3'd5;
  localparam opcode_t OP_CLEAR = 3'd6;
  localparam opcode_t OP_DUP   = 3'd7;
endpackage

// File: rtl/calculadora_rpn_if.sv
// calculadora_rpn_if: command strobe and status bundle of the RPN calculator.
interface calculadora_rpn_if #(parameter int WIDTH = 8);
  import calc_pkg::*;
  logic [WIDTH-1:0] entrada;
  opcode_t          codigo;
  logic             valido;
  logic [WIDTH-1:0] saida;
  logic             vazio;
  logic             cheio;
  logic             ocupado;
  logic             erro;
  logic             carry;
  modport master (output entrada, codigo, valido,
                  input  saida, vazio, cheio, ocupado, erro, carry);
  modport slave  (input  entrada, codigo, valido,
                  output saida, vazio, cheio, ocupado, erro, carry);
endinterface

// File: rtl/calc_mul_seq.sv
// calc_mul_seq: shift-add multiplier, one multiplier bit per cycle; done marks the last step with product valid.
module calc_mul_seq #(parameter int WIDTH = 8) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int NW = $clog2(WIDTH);
  localparam logic [NW-1:0] LAST = NW'(WIDTH - 1);
  logic               busy_q;
  logic [NW-1:0]      n_q;
  logic [WIDTH-1:0]   mpl_q;
  logic [2*WIDTH-1:0] mcd_q, acc_q;
  // product already folds in the current step so the caller can commit it on the final edge
  assign product = acc_q + (mpl_q[0] ? mcd_q : '0);
  assign done    = busy_q && n_q == LAST;
  assign busy    = busy_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      busy_q <= 1'b0;
      n_q    <= '0;
      mpl_q  <= '0;
      mcd_q  <= '0;
      acc_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      n_q    <= '0;
      mpl_q  <= a;
      mcd_q  <= {{WIDTH{1'b0}}, b};
      acc_q  <= '0;
    end else if (busy_q) begin
      busy_q <= !done;
      n_q    <= n_q + NW'(1);
      mpl_q  <= mpl_q >> 1;
      mcd_q  <= mcd_q << 1;
      acc_q  <= product;
    end
endmodule

// File: rtl/calculadora_rpn.sv
// calculadora_rpn: RPN stack calculator with sticky error and carry flags.
// Define CALC_MUL_EN to build the sequential multiplier; otherwise MUL is an illegal opcode.
module calculadora_rpn
  import calc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  calculadora_rpn_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] C1    = CW'(1);
  localparam logic [CW-1:0] C2    = CW'(2);
  localparam logic [CW-1:0] CFULL = CW'(DEPTH);
  logic [WIDTH-1:0] stk_q [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d, cy_q, cy_d;
  logic             we;
  logic [AW-1:0]    widx, top_idx, nxt_idx;
  logic [WIDTH-1:0] wdata, top, nxt;
  logic [WIDTH:0]   sum;
  logic             empty, full, few, acc;
  assign top_idx = AW'(cnt_q - C1);
  assign nxt_idx = AW'(cnt_q - C2);
  assign top     = stk_q[top_idx];
  assign nxt     = stk_q[nxt_idx];
  assign sum     = {1'b0, nxt} + {1'b0, top};
  assign empty   = cnt_q == '0;
  assign full    = cnt_q == CFULL;
  assign few     = cnt_q < C2;
  assign acc     = bus.valido && !bus.ocupado;
`ifdef CALC_MUL_EN
  logic               mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] prod;
  calc_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (top),
    .b       (nxt),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (prod)
  );
  assign bus.ocupado = mul_busy;
`else
  assign bus.ocupado = 1'b0;
`endif
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    cy_d  = cy_q;
    we    = 1'b0;
    widx  = AW'(cnt_q);
    wdata = bus.entrada;
`ifdef CALC_MUL_EN
    mul_start = 1'b0;
    // the operands stay on the stack while multiplying; they are replaced only on completion
    if (mul_done) begin
      we    = 1'b1;
      widx  = nxt_idx;
      wdata = prod[WIDTH-1:0];
      cy_d  = |prod[2*WIDTH-1:WIDTH];
      cnt_d = cnt_q - C1;
    end else
`endif
    if (acc) begin
      case (bus.codigo)
        OP_PUSH: begin
          err_d = err_q | full;
          we    = !full;
          cnt_d = full ? cnt_q : cnt_q + C1;
        end
        OP_POP: begin
          err_d = err_q | empty;
          cnt_d = empty ? cnt_q : cnt_q - C1;
        end
        OP_ADD, OP_SUB: begin
          err_d = err_q | few;
          we    = !few;
          widx  = nxt_idx;
          wdata = bus.codigo == OP_SUB ? nxt - top : sum[WIDTH-1:0];
          cy_d  = few ? cy_q : (bus.codigo == OP_SUB ? top > nxt : sum[WIDTH]);
          cnt_d = few ? cnt_q : cnt_q - C1;
        end
        OP_MUL: begin
`ifdef CALC_MUL_EN
          err_d     = err_q | few;
          mul_start = !few;
`else
          err_d = 1'b1;
`endif
        end
        OP_CLEAR: begin
          cnt_d = '0;
          err_d = 1'b0;
          cy_d  = 1'b0;
        end
        OP_DUP: begin
          err_d = err_q | empty | full;
          we    = !(empty || full);
          wdata = top;
          cnt_d = (empty || full) ? cnt_q : cnt_q + C1;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
      cy_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      cy_q  <= cy_d;
    end
  // storage is left uncleared: entries above the count are never observed
  always_ff @(posedge clk)
    if (we) stk_q[widx] <= wdata;
  assign bus.saida = empty ? '0 : top;
  assign bus.vazio = empty;
  assign bus.cheio = full;
  assign bus.erro  = err_q;
  assign bus.carry = cy_q;
endmodule

// File: tb/tb_calculadora_rpn.sv
// tb_calculadora_rpn: directed and random commands checked against a queue-based stack model.
module tb_calculadora_rpn;
  import calc_pkg::*;
  localparam int W = 8;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  calculadora_rpn_if #(.WIDTH(W)) bus();
  calculadora_rpn #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  int tests = 0;
  int fails = 0;
  int q[$];
  bit m_err, m_cy;
  int m_left, m_a, m_b;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_err = 0;
    m_cy = 0;
    m_left = 0;
  endtask

  task automatic model_apply(input bit v, input opcode_t op, input int d);
    int a, b, p;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        p = m_a * m_b;
        void'(q.pop_back());
        void'(q.pop_back());
        q.push_back(p % (1 << W));
        m_cy = p >= (1 << W);
      end
      return;
    end
    if (!v) return;
    case (op)
      OP_PUSH: if (q.size() == D) m_err = 1; else q.push_back(d);
      OP_POP: if (q.size() == 0) m_err = 1; else void'(q.pop_back());
      OP_ADD, OP_SUB:
        if (q.size() < 2) m_err = 1;
        else begin
          a = q.pop_back();
          b = q.pop_back();
          if (op == OP_ADD) begin
            q.push_back((b + a) % (1 << W));
            m_cy = (b + a) >= (1 << W);
          end else begin
            q.push_back((b - a + (1 << W)) % (1 << W));
            m_cy = a > b;
          end
        end
      OP_MUL:
`ifdef CALC_MUL_EN
        if (q.size() < 2) m_err = 1;
        else begin
          m_a = q[$];
          m_b = q[$-1];
          m_left = W;
        end
`else
        m_err = 1;
`endif
      OP_CLEAR: model_reset();
      OP_DUP: if (q.size() == 0 || q.size() == D) m_err = 1; else q.push_back(q[$]);
      default: ;
    endcase
  endtask

  task automatic compare();
    check("saida", int'(bus.saida), q.size() > 0 ? q[$] : 0);
    check("vazio", int'(bus.vazio), int'(q.size() == 0));
    check("cheio", int'(bus.cheio), int'(q.size() == D));
    check("ocupado", int'(bus.ocupado), int'(m_left > 0));
    check("erro", int'(bus.erro), int'(m_err));
    check("carry", int'(bus.carry), int'(m_cy));
  endtask

  task automatic step(input bit v, input opcode_t op, input int d);
    bus.valido = v;
    bus.codigo = op;
    bus.entrada = W'(d);
    @(posedge clk);
    model_apply(v, op, d);
    @(negedge clk);
    compare();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_saida"}, int'(bus.saida), 0);
    check({tag, "_vazio"}, int'(bus.vazio), 1);
    check({tag, "_cheio"}, int'(bus.cheio), 0);
    check({tag, "_ocupado"}, int'(bus.ocupado), 0);
    check({tag, "_erro"}, int'(bus.erro), 0);
    check({tag, "_carry"}, int'(bus.carry), 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && m_left > 0; i++) step(0, OP_NOP, 0);
    check("mul_drain_bound", int'(bus.ocupado), 0);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    bus.valido = 1'b0;
    bus.codigo = OP_NOP;
    bus.entrada = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
    step(1, OP_PUSH, 200); step(1, OP_PUSH, 100); step(1, OP_ADD, 0);
    check("add_saida", int'(bus.saida), 44);
    check("add_carry", int'(bus.carry), 1);
    step(1, OP_POP, 0);
    check("add_count1", int'(bus.vazio), 1);
    step(1, OP_CLEAR, 0);
    step(1, OP_PUSH, 5); step(1, OP_PUSH, 9); step(1, OP_SUB, 0);
    check("sub1_saida", int'(bus.saida), 252);
    check("sub1_carry", int'(bus.carry), 1);
    step(1, OP_PUSH, 3); step(1, OP_SUB, 0);
    check("sub2_saida", int'(bus.saida), 249);
    check("sub2_carry", int'(bus.carry), 0);
    step(1, OP_CLEAR, 0);
`ifdef CALC_MUL_EN
    step(1, OP_PUSH, 12); step(1, OP_PUSH, 11); step(1, OP_MUL, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.ocupado) break;
      n++;
      step(i == 2, OP_ADD, 0);
    end
    check("mul_busy_cycles", n, 8);
    check("mul_saida", int'(bus.saida), 132);
    check("mul_carry", int'(bus.carry), 0);
    check("mul_erro", int'(bus.erro), 0);
`else
    step(1, OP_PUSH, 2); step(1, OP_PUSH, 3); step(1, OP_MUL, 0);
    check("mul_off_erro", int'(bus.erro), 1);
    check("mul_off_ocupado", int'(bus.ocupado), 0);
    check("mul_off_saida", int'(bus.saida), 3);
    step(1, OP_POP, 0);
    check("mul_off_next", int'(bus.saida), 2);
`endif
    step(1, OP_CLEAR, 0);
    for (int i = 1; i <= 5; i++) begin
      step(1, OP_PUSH, i);
      if (i == 4) check("full_cheio", int'(bus.cheio), 1);
    end
    check("overflow_erro", int'(bus.erro), 1);
    check("overflow_saida", int'(bus.saida), 4);
    step(1, OP_CLEAR, 0);
    check("clear_vazio", int'(bus.vazio), 1);
    check("clear_erro", int'(bus.erro), 0);
    step(1, OP_POP, 0);
    check("pop_empty_erro", int'(bus.erro), 1);
    check("pop_empty_saida", int'(bus.saida), 0);
    step(1, OP_CLEAR, 0);
    step(1, OP_PUSH, 7); step(1, OP_PUSH, 9); step(1, OP_MUL, 0);
    step(0, OP_NOP, 0); step(0, OP_NOP, 0);
    #2 reset = 1'b0;
    #1 check_reset_values("async_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    compare();
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, opcode_t'($urandom_range(0, 7)), $urandom_range(0, 255));
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
